// File: rtl/instr_fetch.sv
// Instruction fetch unit.
// Requests one instruction at a time from instruction memory, presents the
// decoded opcode/operand fields and the instruction address to the decoder,
// and advances the fetch program counter (or takes a jump) when the decoder
// accepts the instruction. A halt request parks the unit after the current
// instruction is accepted; fetching resumes from the saved program counter.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   imem_req      instruction-memory read request
//   imem_addr     read address, valid while imem_req=1
//   imem_ack      memory completion strobe, imem_rdata valid with it
//   imem_rdata    fetched instruction word (opcode [15:12], operand [11:0])
//   instr_valid   opcode/operand/pc_out hold an instruction for the decoder
//   instr_ready   decoder accepts the presented instruction
//   opcode        opcode field of the presented instruction
//   operand       operand field of the presented instruction
//   pc_out        address of the presented instruction
//   jump          jump decision, honoured only on the accept handshake
//   jump_target   jump destination, sampled together with jump
//   halt          request to stop fetching
//
// State    | meaning
// ---------+------------------------------------------------------------
// IDLE     | out of reset, waiting for halt=0 to start fetching
// FETCH    | request outstanding, address held until imem_ack
// HOLD     | instruction presented, waiting for instr_ready
// HALTED   | parked after an accepted instruction, waiting for halt=0

module instr_fetch #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [3:0]         opcode,
   output logic [11:0]        operand,
   output logic [ADDR_W-1:0]  pc_out,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic               halt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic                imem_req_q, imem_req_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic                instr_valid_q, instr_valid_d;
   logic [3:0]          opcode_q, opcode_d;
   logic [11:0]         operand_q, operand_d;
   logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
   logic [ADDR_W-1:0]   next_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         fetch_pc_q    <= '0;
         imem_req_q    <= 1'b0;
         imem_addr_q   <= '0;
         instr_valid_q <= 1'b0;
         opcode_q      <= '0;
         operand_q     <= '0;
         pc_out_q      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         imem_req_q    <= imem_req_d;
         imem_addr_q   <= imem_addr_d;
         instr_valid_q <= instr_valid_d;
         opcode_q      <= opcode_d;
         operand_q     <= operand_d;
         pc_out_q      <= pc_out_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      imem_req_d    = imem_req_q;
      imem_addr_d   = imem_addr_q;
      instr_valid_d = instr_valid_q;
      opcode_d      = opcode_q;
      operand_d     = operand_q;
      pc_out_d      = pc_out_q;
      // jump overrides the increment, but only on the accept handshake
      next_pc       = jump ? jump_target : fetch_pc_q;

      unique case (state_q)
         IDLE: begin
            if (!halt) begin
               state_d     = FETCH;
               imem_req_d  = 1'b1;
               imem_addr_d = fetch_pc_q;
            end
         end
         FETCH: begin
            // halt is deliberately not looked at: an issued request always completes
            if (imem_ack && imem_req_q) begin
               state_d       = HOLD;
               imem_req_d    = 1'b0;
               instr_valid_d = 1'b1;
               opcode_d      = imem_rdata[15:12];
               operand_d     = imem_rdata[11:0];
               pc_out_d      = fetch_pc_q;
               fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
            end
         end
         HOLD: begin
            if (instr_valid_q && instr_ready) begin
               instr_valid_d = 1'b0;
               fetch_pc_d    = next_pc;
               if (halt) begin
                  state_d = HALTED;
               end else begin
                  state_d     = FETCH;
                  imem_req_d  = 1'b1;
                  imem_addr_d = next_pc;
               end
            end
         end
         HALTED: begin
            if (!halt) begin
               state_d     = FETCH;
               imem_req_d  = 1'b1;
               imem_addr_d = fetch_pc_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign instr_valid = instr_valid_q;
   assign opcode      = opcode_q;
   assign operand     = operand_q;
   assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by
// randomized fetch/accept traffic, checked against a program-counter model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  opcode;
   logic [11:0] operand;
   logic [7:0]  pc_out;
   logic        jump;
   logic [7:0]  jump_target;
   logic        halt;

   int checks   = 0;
   int failures = 0;

   // address of the next instruction the bench expects to be fetched
   logic [7:0] model_pc;

   instr_fetch #(.ADDR_W(8), .INSTR_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .operand     (operand),
      .pc_out      (pc_out),
      .jump        (jump),
      .jump_target (jump_target),
      .halt        (halt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},     {31'd0, imem_req},    32'd0);
      chk({tag, "_addr"},    {24'd0, imem_addr},   32'd0);
      chk({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
      chk({tag, "_opcode"},  {28'd0, opcode},      32'd0);
      chk({tag, "_operand"}, {20'd0, operand},     32'd0);
      chk({tag, "_pc_out"},  {24'd0, pc_out},      32'd0);
   endtask

   // One complete transaction, entered at a negedge with a request expected
   // to be up for model_pc. data is returned after 'waits' wait cycles, the
   // decoder stalls for 'rdly' cycles, then accepts with the given jump/halt.
   task automatic fetch_txn(input logic [15:0] data, input int waits, input int rdly,
                            input logic jmp, input logic [7:0] tgt, input logic hlt);
      halt        = hlt;
      instr_ready = (rdly == 0);
      chk("req_up", {31'd0, imem_req}, 32'd1);
      chk("addr", {24'd0, imem_addr}, {24'd0, model_pc});
      for (int i = 0; i < waits; i++) begin
         imem_ack    = 1'b0;
         jump        = 1'($urandom);
         jump_target = 8'($urandom);
         @(negedge clk);
         chk("req_wait", {31'd0, imem_req}, 32'd1);
         chk("addr_wait", {24'd0, imem_addr}, {24'd0, model_pc});
         chk("valid_wait", {31'd0, instr_valid}, 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      chk("valid_up", {31'd0, instr_valid}, 32'd1);
      chk("opcode", {28'd0, opcode}, {28'd0, data[15:12]});
      chk("operand", {20'd0, operand}, {20'd0, data[11:0]});
      chk("pc_out", {24'd0, pc_out}, {24'd0, model_pc});
      chk("req_drop", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < rdly; i++) begin
         instr_ready = 1'b0;
         imem_ack    = 1'($urandom);
         jump        = 1'($urandom);
         jump_target = 8'($urandom);
         @(negedge clk);
         imem_ack = 1'b0;
         chk("hold_valid", {31'd0, instr_valid}, 32'd1);
         chk("hold_opcode", {28'd0, opcode}, {28'd0, data[15:12]});
         chk("hold_operand", {20'd0, operand}, {20'd0, data[11:0]});
         chk("hold_pc_out", {24'd0, pc_out}, {24'd0, model_pc});
         chk("hold_req", {31'd0, imem_req}, 32'd0);
      end
      instr_ready = 1'b1;
      jump        = jmp;
      jump_target = tgt;
      @(negedge clk);
      instr_ready = 1'b0;
      jump        = 1'b0;
      jump_target = 8'($urandom);
      model_pc    = jmp ? tgt : model_pc + 8'd1;
      chk("valid_clear", {31'd0, instr_valid}, 32'd0);
      if (hlt) begin
         chk("halted_req", {31'd0, imem_req}, 32'd0);
      end else begin
         chk("next_req", {31'd0, imem_req}, 32'd1);
         chk("next_addr", {24'd0, imem_addr}, {24'd0, model_pc});
      end
   endtask

   // Sits in the halted state with stray acks, then releases halt.
   task automatic halted_idle(input int n);
      for (int i = 0; i < n; i++) begin
         imem_ack = 1'($urandom);
         @(negedge clk);
         imem_ack = 1'b0;
         chk("halted_req", {31'd0, imem_req}, 32'd0);
         chk("halted_valid", {31'd0, instr_valid}, 32'd0);
      end
      halt = 1'b0;
      @(negedge clk);
      chk("resume_req", {31'd0, imem_req}, 32'd1);
      chk("resume_addr", {24'd0, imem_addr}, {24'd0, model_pc});
   endtask

   initial begin
      reset       = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 16'h0;
      instr_ready = 1'b0;
      jump        = 1'b0;
      jump_target = 8'h0;
      halt        = 1'b0;
      model_pc    = 8'h00;

      // reset state, then first request to address 0
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      chk("start_req", {31'd0, imem_req}, 32'd1);
      chk("start_addr", {24'd0, imem_addr}, 32'd0);

      // sequential fetch with two wait states
      fetch_txn(16'h2A05, 2, 0, 1'b0, 8'h00, 1'b0);
      // decoder back-pressure for five cycles, zero-wait memory
      fetch_txn(16'h7123, 0, 5, 1'b0, 8'h00, 1'b0);
      fetch_txn(16'h3456, 1, 1, 1'b0, 8'h00, 1'b0);
      // jump accepted at pc 3: pc 4 must never be requested
      fetch_txn(16'h9ABC, 0, 0, 1'b1, 8'h40, 1'b0);
      chk("jump_pc", {24'd0, model_pc}, 32'h40);
      // jump to the top of the address space, then wrap to 0
      fetch_txn(16'h1111, 0, 0, 1'b1, 8'hFF, 1'b0);
      fetch_txn(16'hF00F, 1, 0, 1'b0, 8'h00, 1'b0);
      chk("wrap_pc", {24'd0, imem_addr}, 32'h00);
      // halt during an outstanding fetch, with a jump target saved in halt
      fetch_txn(16'h5A5A, 2, 1, 1'b1, 8'h20, 1'b1);
      halted_idle(4);

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         logic       hlt_r;
         logic       jmp_r;
         hlt_r = ($urandom_range(0, 7) == 0);
         jmp_r = ($urandom_range(0, 3) == 0);
         fetch_txn(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   jmp_r, 8'($urandom), hlt_r);
         if (hlt_r) halted_idle($urandom_range(1, 3));
      end

      // reset in the middle of a fetch, stray ack on the following cycle
      chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("midreset");
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 16'hFFFF;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("post_reset_valid", {31'd0, instr_valid}, 32'd0);
      chk("post_reset_opcode", {28'd0, opcode}, 32'd0);
      model_pc = 8'h00;
      fetch_txn(16'hC0DE, 1, 0, 1'b0, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
